// File: rtl/bus_upsizer_arbiter.sv
// Round-robin arbiter placed in front of a narrow-to-wide bus upsizer.
// Each grant lasts for exactly RATIO accepted beats, so every wide word
// holds data from a single requester. One idle cycle separates grants.
// The owner of every completed word is reported on done_val/done_id.
module bus_upsizer_arbiter #(
  parameter int N_REQ        = 4,
  parameter int S_DATA_WIDTH = 8,
  parameter int M_DATA_WIDTH = 32,
  localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_val,
  input  logic [N_REQ*S_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                req_rdy,
  output logic                            up_val,
  output logic [S_DATA_WIDTH-1:0]         up_data,
  input  logic                            up_rdy,
  output logic                            busy,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            done_val,
  output logic [ID_W-1:0]                 done_id
);

  localparam int RATIO = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  // After reset the pointer sits on the last requester so that
  // requester 0 wins the first arbitration.
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_val_q, done_val_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;

  logic              sel_found;
  logic [ID_W-1:0]   sel_id;
  logic              fire;

  // Round-robin pick: first valid requester starting after the last grant.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!sel_found && req_val[i] &&
            (((32'(last_q) + off) % N_REQ) == i)) begin
          sel_found = 1'b1;
          sel_id    = ID_W'(i);
        end
      end
    end
  end

  // Steer the granted requester onto the upsizer port; others see ready low.
  always_comb begin
    up_val  = 1'b0;
    up_data = '0;
    req_rdy = '0;
    if (state_q == GRANT) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_q == ID_W'(i)) begin
          up_val     = req_val[i];
          up_data    = req_data[i*S_DATA_WIDTH +: S_DATA_WIDTH];
          req_rdy[i] = up_rdy;
        end
      end
    end
  end

  assign fire = up_val & up_rdy;

  // Next-state logic: arbitrate in IDLE, count beats in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    done_val_d = 1'b0;
    done_id_d  = done_id_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (fire) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            done_val_d = 1'b1;
            done_id_d  = grant_q;
            last_d     = grant_q;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial word without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      done_val_q <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      done_val_q <= done_val_d;
      done_id_q  <= done_id_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_q;
  assign done_val = done_val_q;
  assign done_id  = done_id_q;

endmodule

// File: tb/tb_bus_upsizer_arbiter.sv
// Bench for bus_upsizer_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_bus_upsizer_arbiter;

  localparam int N     = 4;
  localparam int SW    = 8;
  localparam int MW    = 32;
  localparam int RATIO = MW / SW;
  localparam int IDW   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val;
  logic [N*SW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            up_val;
  logic [SW-1:0]   up_data;
  logic            up_rdy;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic            done_val;
  logic [IDW-1:0]  done_id;

  initial forever #5 clock = ~clock;

  bus_upsizer_arbiter #(
    .N_REQ(N),
    .S_DATA_WIDTH(SW),
    .M_DATA_WIDTH(MW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_val(req_val),
    .req_data(req_data),
    .req_rdy(req_rdy),
    .up_val(up_val),
    .up_data(up_data),
    .up_rdy(up_rdy),
    .busy(busy),
    .grant_id(grant_id),
    .done_val(done_val),
    .done_id(done_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester sources: each sends dbase + number of beats it has delivered.
  logic [SW-1:0] dbase [N];
  int            seqn  [N];

  // Behavioural model: owner of the bus (-1 = none), beats delivered in the
  // current word, last owner, and the registered done report.
  int m_owner;
  int m_cnt;
  int m_last;
  int m_gid;
  int m_done;
  int m_done_id;

  // Observed history
  logic [SW-1:0] xfer_data [$];
  int            xfer_id   [$];
  int            done_log  [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  task automatic build_data();
    for (int i = 0; i < N; i++) req_data[i*SW +: SW] = dbase[i] + SW'(seqn[i]);
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_cnt     = 0;
    m_last    = N - 1;
    m_gid     = 0;
    m_done    = 0;
    m_done_id = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_val[c]) begin
            m_owner = c;
            m_gid   = c;
            break;
          end
        end
      end else if (req_val[m_owner] && up_rdy) begin
        m_cnt++;
        if (m_cnt == RATIO) begin
          m_done    = 1;
          m_done_id = m_owner;
          m_last    = m_owner;
          m_owner   = -1;
          m_cnt     = 0;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    logic [N-1:0] e_rdy;
    logic         e_val;
    e_rdy = '0;
    e_val = 1'b0;
    if (m_owner >= 0) begin
      e_val = req_val[m_owner];
      if (up_rdy) e_rdy[m_owner] = 1'b1;
    end
    chk("cmp_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("cmp_grant_id", 32'(grant_id), 32'(m_gid));
    chk("cmp_done_val", 32'(done_val), 32'(m_done));
    if (m_done != 0) chk("cmp_done_id", 32'(done_id), 32'(m_done_id));
    chk("cmp_up_val", 32'(up_val), 32'(e_val));
    chk("cmp_req_rdy", 32'(req_rdy), 32'(e_rdy));
    if (m_owner >= 0)
      chk("cmp_up_data", 32'(up_data), 32'(req_data[m_owner*SW +: SW]));
    if (done_val === 1'b1) done_log.push_back(int'(done_id));
  endtask

  // One clock: record transfers just before the edge, advance model and
  // sources at the edge, compare on the following falling edge.
  task automatic tick();
    logic [N-1:0] fired;
    #3;
    fired = req_val & req_rdy;
    if (up_val && up_rdy) begin
      xfer_data.push_back(up_data);
      xfer_id.push_back(int'(grant_id));
    end
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) if (fired[i]) seqn[i]++;
    build_data();
    @(negedge clock);
    compare();
  endtask

  task automatic reset_dut();
    req_val = '0;
    reset   = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) seqn[i] = 0;
    build_data();
    reset = 1'b0;
  endtask

  initial begin
    int xb;
    int db;
    reset   = 1'b1;
    req_val = '1;
    up_rdy  = 1'b1;
    dbase   = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < N; i++) seqn[i] = 0;
    build_data();
    model_reset();
    @(negedge clock);
    tick();
    tick();

    // Reset release with everyone requesting: requester 0 first, four beats
    reset = 1'b0;
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_gid", 32'(grant_id), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_gid", 32'(grant_id), 32'd0);
      chk("t1_up_val", 32'(up_val), 32'd1);
      chk("t1_data", 32'(up_data), 32'(8'h10 + k));
      chk("t1_no_done", 32'(done_val), 32'd0);
    end
    tick();
    chk("t1_done_val", 32'(done_val), 32'd1);
    chk("t1_done_id", 32'(done_id), 32'd0);
    chk("t1_bubble", 32'(busy), 32'd0);
    chk("t1_nxfer", 32'(xfer_data.size()), 32'd4);

    // All four requesting: rotation 0,1,2,3 then back to 0
    repeat (16) tick();
    chk("t2_gid", 32'(grant_id), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_data", 32'(up_data), 32'h14);
    chk("t2_ndone", 32'(done_log.size()), 32'd4);
    for (int j = 0; j < 4 && j < done_log.size(); j++)
      chk("t2_done_order", 32'(done_log[j]), 32'(j));

    // Lone requester 2 is re-granted after each bubble
    reset_dut();
    dbase[2] = 8'h01;
    build_data();
    req_val = 4'b0100;
    xb = xfer_data.size();
    db = done_log.size();
    repeat (10) tick();
    req_val = '0;
    tick();
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_nxfer", 32'(xfer_data.size() - xb), 32'd8);
    for (int j = 0; j < 8 && xb + j < xfer_data.size(); j++) begin
      chk("t3_data", 32'(xfer_data[xb+j]), 32'(j + 1));
      chk("t3_id", 32'(xfer_id[xb+j]), 32'd2);
    end
    chk("t3_ndone", 32'(done_log.size() - db), 32'd2);
    for (int j = db; j < done_log.size(); j++) chk("t3_done_id", 32'(done_log[j]), 32'd2);

    // Granted requester 1 pauses mid-word while requester 3 waits
    reset_dut();
    dbase[1] = 8'hA0;
    dbase[3] = 8'hC0;
    build_data();
    req_val = 4'b1010;
    xb = xfer_data.size();
    tick();
    chk("t4_gid", 32'(grant_id), 32'd1);
    tick();
    tick();
    chk("t4_pre_drop", 32'(xfer_data.size() - xb), 32'd2);
    req_val = 4'b1000;
    repeat (3) begin
      tick();
      chk("t4_hold_val", 32'(up_val), 32'd0);
      chk("t4_rdy3", 32'(req_rdy[3]), 32'd0);
      chk("t4_hold_busy", 32'(busy), 32'd1);
      chk("t4_hold_gid", 32'(grant_id), 32'd1);
    end
    chk("t4_no_xfer", 32'(xfer_data.size() - xb), 32'd2);
    req_val = 4'b1010;
    tick();
    tick();
    chk("t4_done_val", 32'(done_val), 32'd1);
    chk("t4_done_id", 32'(done_id), 32'd1);
    chk("t4_nxfer", 32'(xfer_data.size() - xb), 32'd4);
    for (int j = 0; j < 4 && xb + j < xfer_data.size(); j++)
      chk("t4_data", 32'(xfer_data[xb+j]), 32'(8'hA0 + j));
    tick();
    chk("t4_next_gid", 32'(grant_id), 32'd3);
    chk("t4_next_data", 32'(up_data), 32'hC0);
    req_val = '0;

    // Upsizer ready toggling: one beat per ready cycle, data held on stall
    reset_dut();
    dbase[0] = 8'h50;
    build_data();
    req_val = 4'b0001;
    up_rdy  = 1'b1;
    tick();
    chk("t5_first", 32'(up_data), 32'h50);
    for (int k = 1; k <= 7; k++) begin
      up_rdy = (k % 2 == 1);
      tick();
      if (k < 7) begin
        chk("t5_data", 32'(up_data), 32'(8'h50 + (k + 1) / 2));
        chk("t5_no_done", 32'(done_val), 32'd0);
      end else begin
        chk("t5_done_val", 32'(done_val), 32'd1);
        chk("t5_done_id", 32'(done_id), 32'd0);
      end
    end
    up_rdy = 1'b1;

    // Reset in the middle of a word granted to requester 1
    reset_dut();
    req_val = 4'b0010;
    xb = xfer_data.size();
    tick();
    tick();
    tick();
    chk("t6_two_beats", 32'(xfer_data.size() - xb), 32'd2);
    chk("t6_pre_gid", 32'(grant_id), 32'd1);
    reset   = 1'b1;
    req_val = '1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_gid", 32'(grant_id), 32'd0);
    chk("t6_rst_done", 32'(done_val), 32'd0);
    chk("t6_rst_val", 32'(up_val), 32'd0);
    chk("t6_rst_rdy", 32'(req_rdy), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_gid", 32'(grant_id), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk("t6_done_val", 32'(done_val), 32'd1);
    chk("t6_done_id", 32'(done_id), 32'd0);

    // Randomized traffic, stalls and occasional resets
    repeat (1000) begin
      req_val = N'($urandom);
      up_rdy  = ($urandom_range(3) != 0);
      reset   = ($urandom_range(199) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_upsizer_arbiter.md
Name: bus_upsizer_arbiter

Overview:
- Shares one narrow-to-wide bus upsizer (S_DATA_WIDTH in, M_DATA_WIDTH out) between N_REQ narrow valid/ready requesters.
- Grants one requester for exactly RATIO accepted beats, so each wide output word holds data from a single source. It then re-arbitrates round-robin.
- Sits directly in front of the upsizer's slave port.
- Reports the owner of each completed word so downstream logic can tag the upsizer's m_data.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- S_DATA_WIDTH, 8, narrow beat width.
- M_DATA_WIDTH, 32, upsizer output width. Must be an integer multiple of S_DATA_WIDTH, with a ratio >=2.
- Derived localparam RATIO = M_DATA_WIDTH/S_DATA_WIDTH.
- Derived localparam ID_W = max(1, clog2(N_REQ)).
- Derived localparam CNT_W = max(1, clog2(RATIO)).

Ports:
- clock, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- req_val, input, N_REQ, per-requester valid.
- req_data, input, N_REQ*S_DATA_WIDTH, requester i occupies bits [i*S_DATA_WIDTH +: S_DATA_WIDTH].
- req_rdy, output, N_REQ, per-requester ready.
- up_val, output, 1, valid to upsizer s_val.
- up_data, output, S_DATA_WIDTH, data to upsizer s_data.
- up_rdy, input, 1, ready from upsizer s_rdy.
- busy, output, 1, a grant is active.
- grant_id, output, ID_W, index of the current/last granted requester.
- done_val, output, 1, one-cycle pulse when the RATIO-th beat of a grant is accepted.
- done_id, output, ID_W, owner of the word just completed. Valid only with done_val.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, busy=0, grant_id=0, beat counter=0, done_val=0, done_id=0.
  - Round-robin pointer is set so that requester 0 has the highest priority first.
- Handshake: a beat transfers on a clock edge where up_val&up_rdy=1. This is identical to the selected requester's req_val&req_rdy.
- IDLE:
  - up_val=0, req_rdy=all 0.
  - If any req_val is high, select the first requester with req_val=1, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - Register the selection into grant_id, set busy=1, go to GRANT.
  - Arbitration latency is 1 cycle; no beat transfers in the IDLE cycle.
- GRANT:
  - Combinational mux: up_val=req_val[grant_id], up_data=req_data[grant_id], req_rdy[grant_id]=up_rdy.
  - All other req_rdy bits are 0.
  - Beat counter increments on each transfer.
  - On the transfer where counter==RATIO-1: counter->0, done_val=1 and done_id=grant_id on the next cycle (registered), last_grant=grant_id, state->IDLE, busy->0.
  - A single 1-cycle bubble between grants is required.
- The grant is non-preemptive. The granted requester dropping req_val mid-word holds the grant: the counter is preserved, other requesters wait, and up_val follows req_val. There is no timeout.
- up_rdy low stalls the counter; data and grant are held.
- Requesters are expected to hold data stable while req_val=1 and req_rdy=0. The arbiter does not check this.
- Wrap-around: the pointer wraps from N_REQ-1 to 0. If only one requester is active, it is re-granted after each bubble.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle, following round-robin order.
- req_val of non-granted requesters may change freely during GRANT without effect.
- Reset asserted mid-word: the grant is abandoned immediately. The partial word is the upsizer's responsibility; both blocks share the same reset. No done_val is issued.
- grant_id keeps its last value while IDLE.

Test Plan:
1. Reset with all req_val=1 -> after reset release, busy=0 for 1 cycle. grant_id=0, busy=1. up_rdy=1 constant; requester 0 data 0x10,0x11,0x12,0x13 transfers in 4 consecutive cycles. done_val pulses once with done_id=0 the cycle after the 4th beat.
2. All 4 requesters valid and up_rdy=1 for 20 cycles -> grant order is 0,1,2,3 then 0 again. Each grant lasts exactly 4 transfers plus 1 IDLE cycle. done_id sequence is 0,1,2,3.
3. Only requester 2 valid, sending 0x01..0x08 -> two grants to id 2 with a 1-cycle bubble. done_val is pulsed twice with done_id=2. req_rdy[0,1,3]=0 throughout.
4. Requester 1 granted: drop req_val[1] after beat 2 for 3 cycles while requester 3 is valid -> no transfers in that window. req_rdy[3]=0. The grant holds; after resume, beats 3-4 complete, then requester 3 is granted.
5. up_rdy toggles 1,0,1,0 during a grant -> exactly one transfer per up_rdy=1 cycle. up_data is stable while stalled. done_val follows the 4th accepted beat.
6. Assert reset after beat 2 of a grant to requester 1 -> busy, done_val, counter and grant_id are 0 immediately. Requester 0 wins the next arbitration after release.
